// File: rtl/nfca_rx_tobits.sv
// NFC-A ASK sample stream to Manchester bit decoder.
// Classifies 12-sample half-bits as modulated and frames SOF/bits/EOF.
module nfca_rx_tobits #(
  parameter int MOD_TH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_enable,
  input  logic rx_ask_en,
  input  logic rx_ask,
  output logic rx_bit_en,
  output logic rx_bit,
  output logic rx_end,
  output logic rx_err,
  output logic rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    SOF_H1,
    SOF_H2,
    BIT_H1,
    BIT_H2
  } state_t;

  state_t     state;
  logic [3:0] scnt;
  logic [3:0] ocnt;
  logic       h1;

  logic [3:0] ones;
  logic       last;
  logic       modu;

  // ones includes the current sample; max 12 fits 4 bits
  assign ones = ocnt + {3'd0, rx_ask};
  assign last = (scnt == 4'd11);
  assign modu = (ones >= 4'(MOD_TH));

  always_ff @(posedge clk) begin
    rx_bit_en <= 1'b0;
    rx_end    <= 1'b0;
    rx_err    <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      scnt    <= 4'd0;
      ocnt    <= 4'd0;
      h1      <= 1'b0;
      rx_bit  <= 1'b0;
      rx_busy <= 1'b0;
    end else if (!rx_enable) begin
      state   <= IDLE;
      scnt    <= 4'd0;
      ocnt    <= 4'd0;
      h1      <= 1'b0;
      rx_busy <= 1'b0;
    end else if (rx_ask_en) begin
      if (state == IDLE) begin
        if (rx_ask) begin
          state   <= SOF_H1;
          scnt    <= 4'd1;
          ocnt    <= 4'd1;
          rx_busy <= 1'b1;
        end
      end else if (!last) begin
        scnt <= scnt + 4'd1;
        ocnt <= ones;
      end else begin
        scnt <= 4'd0;
        ocnt <= 4'd0;
        unique case (state)
          SOF_H1: begin
            if (modu) begin
              state <= SOF_H2;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
          SOF_H2: begin
            if (modu) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              rx_err  <= 1'b1;
            end else begin
              state <= BIT_H1;
            end
          end
          BIT_H1: begin
            h1    <= modu;
            state <= BIT_H2;
          end
          BIT_H2: begin
            if (h1 != modu) begin
              rx_bit    <= h1;
              rx_bit_en <= 1'b1;
              state     <= BIT_H1;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              rx_end  <= ~h1;
              rx_err  <= h1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nfca_rx_tobits.sv
// Directed bench for nfca_rx_tobits.
// Samples are strobed every few clocks with rx_ask toggling in between.
module tb_nfca_rx_tobits;

  logic clk = 1'b0;
  logic rst;
  logic rx_enable;
  logic rx_ask_en;
  logic rx_ask;
  logic rx_bit_en;
  logic rx_bit;
  logic rx_end;
  logic rx_err;
  logic rx_busy;

  int errors = 0;
  int checks = 0;
  int nbits = 0;
  int nends = 0;
  int nerrs = 0;
  int nover = 0;
  logic [7:0] bitsr = '0;

  localparam int MOD = -1;

  always #5 clk = ~clk;

  nfca_rx_tobits #(.MOD_TH(4)) dut (
    .clk(clk),
    .rst(rst),
    .rx_enable(rx_enable),
    .rx_ask_en(rx_ask_en),
    .rx_ask(rx_ask),
    .rx_bit_en(rx_bit_en),
    .rx_bit(rx_bit),
    .rx_end(rx_end),
    .rx_err(rx_err),
    .rx_busy(rx_busy)
  );

  always @(negedge clk) begin
    if (rx_bit_en) begin
      nbits++;
      bitsr = {bitsr[6:0], rx_bit};
    end
    if (rx_end) nends++;
    if (rx_err) nerrs++;
    if (int'(rx_bit_en) + int'(rx_end) + int'(rx_err) > 1) nover++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    nbits = 0;
    nends = 0;
    nerrs = 0;
    bitsr = '0;
  endtask

  task automatic gap();
    repeat (2) begin
      @(negedge clk);
      rx_ask = ~rx_ask;
    end
  endtask

  task automatic sample(input logic a);
    @(negedge clk);
    rx_ask_en = 1'b1;
    rx_ask = a;
    @(negedge clk);
    rx_ask_en = 1'b0;
  endtask

  // kind MOD: 1,1,0 x4; otherwise 'kind' leading ones then zeros
  task automatic half(input int kind);
    for (int i = 0; i < 12; i++) begin
      if (kind == MOD) sample(i % 3 != 2);
      else sample(i < kind);
      if (i != 11) gap();
    end
  endtask

  task automatic bit_(input logic b);
    if (b) begin
      half(MOD);
      half(0);
    end else begin
      half(0);
      half(MOD);
    end
  endtask

  task automatic sof();
    half(MOD);
    half(0);
  endtask

  task automatic eof();
    half(0);
    half(0);
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {27'd0, rx_busy, rx_bit_en, rx_bit, rx_end, rx_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx_enable = 1'b1;
    rx_ask_en = 1'b0;
    rx_ask = 1'b0;
    repeat (3) @(negedge clk);
    outs_zero("reset_outs");
    rst = 1'b0;

    // idle toggling without strobe
    clr();
    repeat (20) begin
      @(negedge clk);
      rx_ask = ~rx_ask;
    end
    chk("idle_toggle_busy", rx_busy, 0);

    // SOF, 1, 0, 1, EOF
    clr();
    sof();
    chk("a_busy_sof", rx_busy, 1);
    half(MOD);
    half(0);
    chk("a_lat_bit_en", rx_bit_en, 1);
    chk("a_lat_bit", rx_bit, 1);
    @(negedge clk);
    chk("a_bit_en_1clk", rx_bit_en, 0);
    bit_(1'b0);
    bit_(1'b1);
    eof();
    chk("a_end_lat", rx_end, 1);
    @(negedge clk);
    chk("a_nbits", nbits, 3);
    chk("a_bits", bitsr[2:0], 3'b101);
    chk("a_nends", nends, 1);
    chk("a_nerrs", nerrs, 0);
    chk("a_busy_end", rx_busy, 0);
    chk("a_hold_bit", rx_bit, 1);

    // glitch: single one then zeros
    clr();
    sample(1'b1);
    chk("b_busy_h1", rx_busy, 1);
    gap();
    for (int i = 0; i < 11; i++) begin
      sample(1'b0);
      gap();
    end
    chk("b_busy", rx_busy, 0);
    chk("b_pulses", nbits + nends + nerrs, 0);

    // SOF second half modulated
    clr();
    half(MOD);
    half(MOD);
    chk("c_err_lat", rx_err, 1);
    @(negedge clk);
    chk("c_nerrs", nerrs, 1);
    chk("c_busy", rx_busy, 0);

    // SOF then bit with both halves modulated
    clr();
    sof();
    half(MOD);
    half(MOD);
    @(negedge clk);
    chk("c2_nerrs", nerrs, 1);
    chk("c2_other", nbits + nends, 0);
    chk("c2_busy", rx_busy, 0);

    // threshold 3 versus 4 ones
    clr();
    half(3);
    gap();
    chk("d_sof3_busy", rx_busy, 0);
    half(4);
    gap();
    chk("d_sof4_busy", rx_busy, 1);
    half(0);
    half(4);
    half(3);
    half(3);
    half(4);
    eof();
    @(negedge clk);
    chk("d_nbits", nbits, 2);
    chk("d_bits", bitsr[1:0], 2'b10);
    chk("d_nends", nends, 1);
    chk("d_nerrs", nerrs, 0);

    // reset mid-frame after 2 bits
    clr();
    sof();
    bit_(1'b0);
    bit_(1'b1);
    for (int i = 0; i < 5; i++) begin
      sample(1'b1);
      gap();
    end
    chk("e_nbits_pre", nbits, 2);
    @(negedge clk);
    rst = 1'b1;
    rx_ask_en = 1'b1;
    rx_ask = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_ask_en = 1'b0;
    outs_zero("e_rst_outs");
    clr();
    sof();
    bit_(1'b0);
    eof();
    @(negedge clk);
    chk("e_nbits", nbits, 1);
    chk("e_bit", bitsr[0], 0);
    chk("e_nends", nends, 1);

    // rx_enable low on the closing sample of a bit
    clr();
    sof();
    bit_(1'b1);
    bit_(1'b0);
    half(MOD);
    for (int i = 0; i < 11; i++) begin
      sample(1'b0);
      gap();
    end
    @(negedge clk);
    rx_ask_en = 1'b1;
    rx_ask = 1'b0;
    rx_enable = 1'b0;
    @(negedge clk);
    rx_ask_en = 1'b0;
    outs_zero("f_dis_outs");
    @(negedge clk);
    rx_enable = 1'b1;
    chk("f_nbits_block", nbits, 2);
    clr();
    sof();
    bit_(1'b1);
    eof();
    @(negedge clk);
    chk("f_nbits", nbits, 1);
    chk("f_bit", bitsr[0], 1);
    chk("f_nends", nends, 1);
    chk("f_nerrs", nerrs, 0);

    chk("one_hot_pulses", nover, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
